// File: rtl/image_dram_pkg.sv
// Shared types, AXI constants and burst sizing for the image DRAM reader.
// The write-side counterpart will reuse these.
package image_dram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    AR   = 2'd2,
    R    = 2'd3
  } reader_state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
  localparam int unsigned AXI_4K_BEATS   = 256;
  localparam int unsigned BEAT_SHIFT     = 4;

  // Largest burst that fits the remaining request, the burst cap and the current 4 KB page.
  function automatic logic [8:0] calc_burst_len(
    input logic [8:0] remaining,
    input logic [7:0] addr_11_4,
    input logic [8:0] max_len
  );
    logic [8:0] to_page;
    logic [8:0] len;
    to_page = 9'(AXI_4K_BEATS) - {1'b0, addr_11_4};
    len     = remaining;
    if (max_len < len) len = max_len;
    if (to_page < len) len = to_page;
    return len;
  endfunction

endpackage

// File: rtl/image_dram_reader_if.sv
// AXI4 read-address and read-data channels between the reader and the HP port.
interface image_dram_reader_if #(
  parameter int unsigned ADDR_W = 39,
  parameter int unsigned DATA_W = 128
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/image_dram_reader.sv
// AXI4 read master: splits one image read request into page-safe bursts,
// issues them one at a time and forwards the returned beats in order.
module image_dram_reader
  import image_dram_pkg::*;
#(
  parameter int unsigned DRAM_ADDR_WIDTH = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 128,
  parameter int unsigned MAX_BURST_LEN   = 16
) (
  input  logic                       clk_pixel,
  input  logic                       image_dram_reader_reset,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       reader_error,
  image_dram_reader_if.master        m_axi
);

  localparam logic [8:0] MAX_LEN = 9'(MAX_BURST_LEN);

  reader_state_t              state;
  logic [DRAM_ADDR_WIDTH-1:0] cur_addr;
  logic [8:0]                 remaining;
  logic [8:0]                 burst;
  logic [7:0]                 beat_cnt;

  logic [8:0] next_burst_c;
  logic       beat_c;
  logic       last_beat_c;

  assign next_burst_c = calc_burst_len(remaining, cur_addr[11:4], MAX_LEN);
  assign beat_c       = m_axi.rvalid && m_axi.rready;
  assign last_beat_c  = (beat_cnt == 8'd0);

  assign m_axi.arsize  = AXI_SIZE_16B;
  assign m_axi.arburst = AXI_BURST_INCR;

  always_ff @(posedge clk_pixel) begin
    if (image_dram_reader_reset) begin
      state                <= IDLE;
      cur_addr             <= '0;
      remaining            <= '0;
      burst                <= '0;
      beat_cnt             <= '0;
      dram_read_busy       <= 1'b0;
      dram_read_data       <= '0;
      dram_read_data_valid <= 1'b0;
      reader_error         <= 1'b0;
      m_axi.araddr         <= '0;
      m_axi.arlen          <= '0;
      m_axi.arvalid        <= 1'b0;
      m_axi.rready         <= 1'b0;
    end else begin
      dram_read_data_valid <= 1'b0;

      // A strobe outside IDLE is dropped but flagged.
      if (dram_read_en && (state != IDLE)) reader_error <= 1'b1;

      unique case (state)
        IDLE: begin
          if (dram_read_en) begin
            cur_addr       <= {dram_read_addr[DRAM_ADDR_WIDTH-1:BEAT_SHIFT], 4'h0};
            remaining      <= 9'(dram_read_len) + 9'd1;
            dram_read_busy <= 1'b1;
            state          <= CALC;
            if (dram_read_addr[3:0] != 4'h0) reader_error <= 1'b1;
          end
        end

        CALC: begin
          burst         <= next_burst_c;
          beat_cnt      <= 8'(next_burst_c - 9'd1);
          m_axi.araddr  <= cur_addr;
          m_axi.arlen   <= 8'(next_burst_c - 9'd1);
          m_axi.arvalid <= 1'b1;
          state         <= AR;
        end

        AR: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= R;
          end
        end

        R: begin
          if (beat_c) begin
            dram_read_data       <= m_axi.rdata;
            dram_read_data_valid <= 1'b1;
            if (m_axi.rresp != AXI_RESP_OKAY) reader_error <= 1'b1;
            if (m_axi.rlast != last_beat_c)   reader_error <= 1'b1;

            if (last_beat_c) begin
              remaining    <= remaining - burst;
              cur_addr     <= cur_addr + (DRAM_ADDR_WIDTH'(burst) << BEAT_SHIFT);
              m_axi.rready <= 1'b0;
              if (remaining == burst) begin
                dram_read_busy <= 1'b0;
                state          <= IDLE;
              end else begin
                state <= CALC;
              end
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_dram_reader.sv
// Self-checking bench for image_dram_reader: vector table, corner-case sequences
// and random requests checked against a burst/beat reference model.
module tb_image_dram_reader;

  localparam int unsigned AW  = 39;
  localparam int unsigned DW  = 128;
  localparam int unsigned MBL = 16;
  localparam int          NV  = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    bit            stall;
    int            bad_resp;
    int            early_last;
    int            err_from;
    int            exp_nb;
    bit            exp_err;
  } vec_t;

  logic          clk_pixel = 1'b0;
  logic          rst;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          req_en;
  logic          busy;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          err;

  int total;
  int bad;

  image_dram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) m_axi ();

  image_dram_reader #(
    .DRAM_ADDR_WIDTH(AW),
    .DRAM_DATA_WIDTH(DW),
    .MAX_BURST_LEN  (MBL)
  ) dut (
    .clk_pixel              (clk_pixel),
    .image_dram_reader_reset(rst),
    .dram_read_addr         (req_addr),
    .dram_read_len          (req_len),
    .dram_read_en           (req_en),
    .dram_read_busy         (busy),
    .dram_read_data         (rd_data),
    .dram_read_data_valid   (rd_valid),
    .reader_error           (err),
    .m_axi                  (m_axi)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Slave-model knobs and scoreboard state
  bit            stall;
  int            bad_resp;
  int            early_last;
  int            err_from;
  ar_t           ar_seen[$];
  ar_t           exp_ar[$];
  ar_t           pend[$];
  logic [DW-1:0] exp_data[$];
  int            rbeat;
  int            req_beat;
  int            obs_beats;
  bit            ar_wait;
  ar_t           held;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    logic [63:0] h;
    h = 64'(a) * 64'h9E37_79B9_7F4A_7C15;
    return {h ^ 64'hDEAD_BEEF_0000_0000, 64'(a)};
  endfunction

  // Reference model: page-safe split into capped bursts, beats by address.
  function automatic void build_model(input logic [AW-1:0] addr, input logic [7:0] len);
    logic [AW-1:0] a;
    int            rem;
    int            room;
    int            b;
    exp_ar.delete();
    exp_data.delete();
    a   = addr & ~AW'(15);
    rem = int'(len) + 1;
    for (int i = 0; i < rem; i++) exp_data.push_back(beat_data(a + AW'(i * 16)));
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 16;
      b    = rem;
      if (b > int'(MBL)) b = int'(MBL);
      if (b > room) b = room;
      exp_ar.push_back('{addr: a, len: 8'(b - 1)});
      a   = a + AW'(b * 16);
      rem = rem - b;
    end
  endfunction

  // AXI slave: decisions made at negedge take effect on the following posedge.
  always @(negedge clk_pixel) begin
    if (rst) begin
      m_axi.arready = 1'b0;
      m_axi.rvalid  = 1'b0;
      m_axi.rlast   = 1'b0;
      m_axi.rresp   = 2'b00;
      m_axi.rdata   = '0;
      pend.delete();
      rbeat    = 0;
      req_beat = 0;
      ar_wait  = 1'b0;
    end else begin
      if (pend.size() != 0 && (!stall || $urandom_range(0, 3) != 0)) begin
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = beat_data(pend[0].addr + AW'(rbeat * 16));
        m_axi.rresp  = (req_beat == bad_resp) ? 2'b10 : 2'b00;
        m_axi.rlast  = (rbeat == int'(pend[0].len)) || (req_beat == early_last);
        if (m_axi.rready) begin
          rbeat++;
          req_beat++;
          if (rbeat > int'(pend[0].len)) begin
            void'(pend.pop_front());
            rbeat = 0;
          end
        end
      end else begin
        m_axi.rvalid = 1'b0;
        m_axi.rlast  = 1'b0;
        m_axi.rresp  = 2'b00;
      end

      m_axi.arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axi.arvalid) begin
        if (ar_wait) begin
          check("ar_stable_addr", 128'(m_axi.araddr), 128'(held.addr));
          check("ar_stable_len", 128'(m_axi.arlen), 128'(held.len));
        end
        if (m_axi.arready) begin
          ar_seen.push_back('{addr: m_axi.araddr, len: m_axi.arlen});
          pend.push_back('{addr: m_axi.araddr, len: m_axi.arlen});
          ar_wait = 1'b0;
        end else begin
          ar_wait = 1'b1;
          held    = '{addr: m_axi.araddr, len: m_axi.arlen};
        end
      end else begin
        ar_wait = 1'b0;
      end
    end
  end

  // Output monitor: in-order data and the error flag as each beat emerges.
  always @(negedge clk_pixel) begin
    if (!rst && rd_valid) begin
      if (exp_data.size() == 0) begin
        check("extra_beat", 128'(obs_beats), 128'(-1));
      end else begin
        check("beat_data", rd_data, exp_data.pop_front());
      end
      if (err_from >= 0) check("err_at_beat", 128'(err), 128'(obs_beats >= err_from));
      obs_beats++;
    end
  end

  task automatic do_reset();
    rst    = 1'b1;
    req_en = 1'b0;
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(rd_valid), 128'(0));
    check("rst_data", rd_data, 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_arvalid", 128'(m_axi.arvalid), 128'(0));
    check("rst_rready", 128'(m_axi.rready), 128'(0));
    check("rst_araddr", 128'(m_axi.araddr), 128'(0));
    check("rst_arlen", 128'(m_axi.arlen), 128'(0));
    check("arsize", 128'(m_axi.arsize), 128'(3'b100));
    check("arburst", 128'(m_axi.arburst), 128'(2'b01));
    rst = 1'b0;
    ar_seen.delete();
    obs_beats = 0;
    @(negedge clk_pixel);
  endtask

  task automatic start_req(input logic [AW-1:0] addr, input logic [7:0] len);
    build_model(addr, len);
    ar_seen.delete();
    obs_beats = 0;
    req_addr  = addr;
    req_len   = len;
    req_en    = 1'b1;
    @(negedge clk_pixel);
    req_en = 1'b0;
    check("lat_busy", 128'(busy), 128'(1));
    check("lat_arvalid_c1", 128'(m_axi.arvalid), 128'(0));
    @(negedge clk_pixel);
    check("lat_arvalid_c2", 128'(m_axi.arvalid), 128'(1));
  endtask

  task automatic wait_done(input int n);
    int cyc;
    cyc = 0;
    while (!(obs_beats >= n && !busy) && cyc < 4000) begin
      @(negedge clk_pixel);
      cyc++;
    end
    if (cyc >= 4000) check("timeout_beats", 128'(obs_beats), 128'(n));
    repeat (4) @(negedge clk_pixel);
  endtask

  task automatic do_req(input logic [AW-1:0] addr, input logic [7:0] len,
                        input int exp_nb, input bit exp_err, input bit poke);
    start_req(addr, len);
    if (poke) begin
      @(negedge clk_pixel);
      req_addr = addr + AW'(32'h3000);
      req_len  = 8'd3;
      req_en   = 1'b1;
      @(negedge clk_pixel);
      req_en = 1'b0;
    end
    wait_done(int'(len) + 1);
    check("done_busy", 128'(busy), 128'(0));
    check("done_err", 128'(err), 128'(exp_err));
    check("done_beats", 128'(obs_beats), 128'(int'(len) + 1));
    check("ar_count", 128'(ar_seen.size()), 128'(exp_nb >= 0 ? exp_nb : exp_ar.size()));
    for (int i = 0; i < ar_seen.size() && i < exp_ar.size(); i++) begin
      check("araddr", 128'(ar_seen[i].addr), 128'(exp_ar[i].addr));
      check("arlen", 128'(ar_seen[i].len), 128'(exp_ar[i].len));
    end
  endtask

  task automatic run_vec(input vec_t v);
    do_reset();
    stall      = v.stall;
    bad_resp   = v.bad_resp;
    early_last = v.early_last;
    err_from   = v.err_from;
    do_req(v.addr, v.len, v.exp_nb, v.exp_err, 1'b0);
  endtask

  initial begin
    vec_t vecs[NV];
    vec_t v;
    int   cyc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req_en = 1'b0;
    req_addr = '0;
    req_len  = '0;
    stall = 1'b0;
    bad_resp = -1;
    early_last = -1;
    err_from = 1000;
    obs_beats = 0;
    m_axi.arready = 1'b0;
    m_axi.rvalid  = 1'b0;
    m_axi.rlast   = 1'b0;
    m_axi.rresp   = 2'b00;
    m_axi.rdata   = '0;

    //          addr               len     stall bad  early err_from nb  err
    vecs[0] = '{39'h00_0000_1000, 8'd7,   1'b0, -1,  -1,   1000,    1,  1'b0};
    vecs[1] = '{39'h00_0000_0F80, 8'd31,  1'b0, -1,  -1,   1000,    3,  1'b0};
    vecs[2] = '{39'h00_0000_2000, 8'd255, 1'b1, -1,  -1,   1000,    16, 1'b0};
    vecs[3] = '{39'h00_0000_3000, 8'd7,   1'b0, 3,   -1,   3,       1,  1'b1};
    vecs[4] = '{39'h00_0000_4000, 8'd7,   1'b0, -1,  2,    2,       1,  1'b1};
    vecs[5] = '{39'h00_0000_5008, 8'd3,   1'b1, -1,  -1,   0,       1,  1'b1};
    vecs[6] = '{39'h7F_FFFF_FFF0, 8'd3,   1'b0, -1,  -1,   1000,    2,  1'b0};
    vecs[7] = '{39'h00_0000_1FF0, 8'd1,   1'b0, -1,  -1,   1000,    2,  1'b0};

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Strobe while busy is dropped and flagged
    do_reset();
    stall = 1'b0; bad_resp = -1; early_last = -1; err_from = -1;
    do_req(39'h00_0000_6000, 8'd7, 1, 1'b1, 1'b1);

    // Reset during the data phase aborts; the next request runs clean
    do_reset();
    err_from = 1000;
    start_req(39'h00_0000_7000, 8'd15);
    cyc = 0;
    while (obs_beats < 4 && cyc < 200) begin
      @(negedge clk_pixel);
      cyc++;
    end
    if (cyc >= 200) check("timeout_midr", 128'(obs_beats), 128'(4));
    rst = 1'b1;
    @(negedge clk_pixel);
    check("midr_busy", 128'(busy), 128'(0));
    check("midr_arvalid", 128'(m_axi.arvalid), 128'(0));
    check("midr_rready", 128'(m_axi.rready), 128'(0));
    check("midr_valid", 128'(rd_valid), 128'(0));
    @(negedge clk_pixel);
    rst = 1'b0;
    exp_data.delete();
    @(negedge clk_pixel);
    do_req(39'h00_0000_8000, 8'd15, 1, 1'b0, 1'b0);

    // Random requests against the model
    for (int i = 0; i < 6; i++) begin
      v.addr       = AW'({$urandom, $urandom}) & ~AW'(15);
      v.len        = 8'($urandom_range(0, 255));
      v.stall      = 1'($urandom_range(0, 1));
      v.bad_resp   = -1;
      v.early_last = -1;
      v.err_from   = 1000;
      v.exp_nb     = -1;
      v.exp_err    = 1'b0;
      run_vec(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
